// File: rtl/uw_insert_rot.sv
// LRPT transmit framer: prepends the rotated unique word to each frame and
// streams held soft I/Q payload pairs out as a rotated serial soft-byte stream.
module uw_insert_rot #(
  parameter int unsigned BYTES_PER_FRAME = 80,
  parameter logic [7:0]  SYNC_WORD       = 8'h27
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic [7:0] soft_in_0,
  input  logic [7:0] soft_in_1,
  input  logic       valid_in,
  output logic       ready_in,
  input  logic [1:0] rot_sel,
  input  logic       ready_tx,
  output logic       valid_out,
  output logic [7:0] soft_out,
  output logic       sof_out
);

  localparam int unsigned      POS_W    = $clog2(BYTES_PER_FRAME);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(BYTES_PER_FRAME - 1);
  localparam logic [POS_W-1:0] SYNC_LEN = POS_W'(8);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             pair_full_q, pair_full_d;
  logic [7:0]       pair_i_q, pair_i_d;
  logic [7:0]       pair_q_q, pair_q_d;
  logic [1:0]       frame_rot_q, frame_rot_d;
  logic             valid_out_q, valid_out_d;
  logic [7:0]       soft_out_q, soft_out_d;
  logic             sof_out_q, sof_out_d;

  logic [7:0]  sync_byte [8];
  logic        slot_free, in_sync, have_byte, load, q_load, accept, at_start;
  logic [7:0]  src_a, src_b, load_byte;
  logic [1:0]  eff_rot;
  logic [15:0] rot_pair;

  // Unique-word symbols as soft bytes, MSB of the word first.
  for (genvar gi = 0; gi < 8; gi++) begin : g_sync
    assign sync_byte[gi] = SYNC_WORD[7-gi] ? 8'h7F : 8'h80;
  end

  function automatic logic [15:0] rotate(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] rot);
    case (rot)
      2'd0:    rotate = {a, b};
      2'd1:    rotate = {~b, a};
      2'd2:    rotate = {~a, ~b};
      default: rotate = {b, ~a};
    endcase
  endfunction

  assign slot_free = !valid_out_q || ready_tx;
  assign in_sync   = (pos_q < SYNC_LEN);
  assign at_start  = (pos_q == '0);
  // Odd payload positions always have data: the pair stays held until its Q loads.
  assign have_byte = in_sync || pos_q[0] || pair_full_q;
  assign load      = slot_free && have_byte;
  assign q_load    = slot_free && !in_sync && pos_q[0];
  assign ready_in  = !pair_full_q || q_load;
  assign accept    = valid_in && ready_in;

  // The first sync byte already uses the rotation being latched for the new frame.
  assign eff_rot = at_start ? rot_sel : frame_rot_q;

  always_comb begin
    src_a = pair_i_q;
    src_b = pair_q_q;
    if (in_sync) begin
      src_a = sync_byte[{pos_q[2:1], 1'b0}];
      src_b = sync_byte[{pos_q[2:1], 1'b1}];
    end
  end

  assign rot_pair  = rotate(src_a, src_b, eff_rot);
  assign load_byte = pos_q[0] ? rot_pair[7:0] : rot_pair[15:8];

  always_comb begin
    pos_d       = pos_q;
    pair_full_d = pair_full_q;
    pair_i_d    = pair_i_q;
    pair_q_d    = pair_q_q;
    frame_rot_d = frame_rot_q;
    valid_out_d = valid_out_q;
    soft_out_d  = soft_out_q;
    sof_out_d   = sof_out_q;

    if (slot_free) begin
      // A free slot with nothing to load becomes a bubble and pos holds.
      valid_out_d = load;
      if (load) begin
        soft_out_d = load_byte;
        sof_out_d  = at_start;
        pos_d      = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        if (at_start) begin
          frame_rot_d = rot_sel;
        end
      end
    end

    if (q_load) begin
      pair_full_d = 1'b0;
    end
    // A pair accepted alongside the Q load of the previous one refills the register.
    if (accept) begin
      pair_full_d = 1'b1;
      pair_i_d    = soft_in_0;
      pair_q_d    = soft_in_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      pos_q       <= '0;
      pair_full_q <= 1'b0;
      pair_i_q    <= 8'h00;
      pair_q_q    <= 8'h00;
      frame_rot_q <= 2'd0;
      valid_out_q <= 1'b0;
      soft_out_q  <= 8'h00;
      sof_out_q   <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      pair_full_q <= pair_full_d;
      pair_i_q    <= pair_i_d;
      pair_q_q    <= pair_q_d;
      frame_rot_q <= frame_rot_d;
      valid_out_q <= valid_out_d;
      soft_out_q  <= soft_out_d;
      sof_out_q   <= sof_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign soft_out  = soft_out_q;
  assign sof_out   = sof_out_q;

endmodule

// File: doc/uw_insert_rot.md
# uw_insert_rot

Transmit-side framer for the LRPT soft-symbol path, and the inverse of the unique-word synchronizer. It accepts soft I/Q payload pairs and emits a serial soft-byte stream of fixed-length frames. Each frame starts with the 8-symbol unique word, and every symbol pair is given a selectable QPSK phase rotation. It drives the synchronizer in loopback benches and hardware self-test, and produces streams with known rotation and frame alignment.

## Interface
- BYTES_PER_FRAME, 80: soft bytes per frame, unique word included. Must be even and ≥ 10.
- SYNC_WORD, 8'h27: unique word, sent MSB first. Bit 1 maps to 8'h7F, bit 0 maps to 8'h80.
- clk, input, 1: the only clock.
- rst_in, input, 1: reset, synchronous, active-high.
- soft_in_0, input, 8: payload I soft value (two's complement).
- soft_in_1, input, 8: payload Q soft value.
- valid_in, input, 1: a payload pair is presented.
- ready_in, output, 1: the block accepts the pair this cycle. Combinational.
- rot_sel, input, 2: rotation for the next frame. 0 = 0°, 1 = 90°, 2 = 180°, 3 = 270°.
- ready_tx, input, 1: downstream accepts soft_out this cycle.
- valid_out, output, 1: soft_out is valid. Registered.
- soft_out, output, 8: serial soft byte. Registered.
- sof_out, output, 1: high with the first unique-word byte of each frame. Registered.

## Operation
- Position counter pos runs 0..BYTES_PER_FRAME-1 and counts the byte to be loaded next into the output register.
  - Increments on every output-register load.
  - Wraps from BYTES_PER_FRAME-1 to 0.
- Pair holding register: pair_full flag plus raw soft_in_0/1.
  - A pair is accepted when valid_in && ready_in.
  - ready_in = !pair_full || (an odd-position payload byte is loaded this cycle). With this, a continuous input sustains 1 byte/cycle.
- Output slot is free when !valid_out || ready_tx. On a free slot:
  - pos < 8: load the sync byte for symbol pos, rotated. Sync bytes are always loadable and need no input.
  - pos ≥ 8, pos even, pair_full: load the rotated I of the held pair.
  - pos ≥ 8, pos odd: load the rotated Q and clear pair_full. The pair stays full until this load, so this case always has data.
  - pos ≥ 8, even, !pair_full: load nothing. valid_out goes 0 and pos holds (bubble).
- Rotation of pair (a,b), where ~ is bitwise inversion (sign flip, 7F↔80, 00→FF, no saturation):
  - 0°: (a,b)
  - 90°: (~b,a)
  - 180°: (~a,~b)
  - 270°: (b,~a)
- Sync symbols are paired (0,1), (2,3), (4,5), (6,7) and rotated the same way.
- rot_sel is latched into frame_rot on the load at pos 0. Changes mid-frame take effect at the next frame.
- sof_out is set on the pos-0 load and cleared on every other load.

## Timing
- Reset values:
  - Outputs: valid_out 0, soft_out 8'h00, sof_out 0, ready_in 1.
  - Internal: pos 0, pair_full 0, frame_rot 0.
- Latency:
  - First edge after rst_in falls: sync byte 0 loads, so valid_out = 1 one cycle after reset release.
  - Pair accepted at edge N: its I byte appears at edge N+1 at the earliest, when pos is even ≥ 8 and the slot is free.
- While valid_out && !ready_tx, soft_out, sof_out and valid_out hold stable. pos and frame_rot do not change.
- Accepting a pair and loading its Q byte in the same cycle means: the clear and the set of pair_full occur together, and the new pair wins.
- rst_in asserted mid-frame: next cycle is the full reset state. The held pair and the in-flight output byte are discarded. The next frame restarts at sync byte 0.
- No output byte is duplicated or dropped. Every accepted pair appears exactly once, I then Q, in acceptance order.

## Test plan
- Reset, rot_sel=0, ready_tx=1, valid_in=0:
  - Output 80,80,7F,80,80,7F,7F,7F.
  - sof_out high on the first byte only.
  - Then valid_out=0 with pos held at 8.
- Continuous pairs (01,02), (03,04), … (47,48), then the next frame's pairs, with ready_tx=1:
  - 80 valid bytes with no gaps: sync, then 01..48.
  - sof_out again at byte 80.
- rot_sel=2: sync 7F,7F,80,7F,7F,80,80,80. Pair (01,02) → FE,FD.
- rot_sel=1:
  - Sync starts 7F,80. Pair (10,20) → DF,10.
  - rot_sel switched to 3 at pos 30: the current frame stays 90°. The next frame's sync starts 80,7F.
- Random ready_tx and valid_in toggling over 3 frames:
  - Outputs stable during stalls.
  - Scoreboard matches the expected sequence exactly.
  - ready_in=0 only while a pair is held and no Q load occurs.
- rst_in pulsed at pos 40 with a pair held:
  - Next cycle valid_out=0, ready_in=1.
  - After release, sof_out with byte 80 (rot_sel=0).
